// File: rtl/fetch_stage_pkg.sv
// Shared constants and state encoding for the instruction-fetch stage.
package fetch_stage_pkg;

    localparam int                 WORD_WIDTH   = 32;
    localparam logic [WORD_WIDTH-1:0] RESET_PC_DEF = 32'h0000_0000;
    localparam int                 PC_STEP_DEF  = 4;

    typedef enum logic [1:0] {
        FETCH_S = 2'd0,
        WAIT_S  = 2'd1,
        DRAIN_S = 2'd2,
        HOLD_S  = 2'd3
    } fetch_state_e;

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory request/response bus: req/gnt request phase, rvalid response phase.
interface fetch_stage_if #(
    parameter int W = fetch_stage_pkg::WORD_WIDTH
);
    logic         req;
    logic [W-1:0] addr;
    logic         gnt;
    logic         rvalid;
    logic [W-1:0] rdata;

    modport master (output req, output addr, input gnt, input rvalid, input rdata);
    modport slave  (input req, input addr, output gnt, output rvalid, output rdata);
endinterface

// File: rtl/fetch_stage_pc_gen.sv
// Program counter register with sequential increment (wrapping) and branch redirect.
module fetch_pc_gen
    import fetch_stage_pkg::*;
#(
    parameter int                     W        = WORD_WIDTH,
    parameter logic [WORD_WIDTH-1:0]  RESET_PC = RESET_PC_DEF,
    parameter int                     PC_STEP  = PC_STEP_DEF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         redirect,
    input  logic [W-1:0] redirect_addr,
    input  logic         advance,
    output logic [W-1:0] pc_q,
    output logic [W-1:0] pc_inc
);

    assign pc_inc = pc_q + W'(PC_STEP);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q <= W'(RESET_PC);
        end else if (redirect) begin
            pc_q <= redirect_addr;
        end else if (advance) begin
            pc_q <= pc_inc;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: request FSM, 1-entry skid buffer and IF/ID register.
// Optional performance counters are enabled with FETCH_PERF_CNT_EN.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter int                     WORD_WIDTH_P = WORD_WIDTH,
    parameter logic [WORD_WIDTH-1:0]  RESET_PC     = RESET_PC_DEF,
    parameter int                     PC_STEP      = PC_STEP_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    Freeze,
    input  logic                    Branch_taken,
    input  logic [WORD_WIDTH_P-1:0] Branch_Address,
    fetch_stage_if.master           imem,
    output logic [WORD_WIDTH_P-1:0] PC_out,
    output logic [WORD_WIDTH_P-1:0] instruction_out,
    output logic                    valid_out
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]             fetch_count,
    output logic [15:0]             flush_count
`endif
);

    fetch_state_e            state_q, state_d;
    logic [WORD_WIDTH_P-1:0] pc_q, pc_inc;
    logic                    skid_valid;
    logic [WORD_WIDTH_P-1:0] skid_pc, skid_instr;
    logic                    load_rsp, load_skid, drain_skid, advance;

    fetch_pc_gen #(
        .W        (WORD_WIDTH_P),
        .RESET_PC (RESET_PC),
        .PC_STEP  (PC_STEP)
    ) u_pc_gen (
        .clk           (clk),
        .rst           (rst),
        .redirect      (Branch_taken),
        .redirect_addr (Branch_Address),
        .advance       (advance),
        .pc_q          (pc_q),
        .pc_inc        (pc_inc)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= FETCH_S;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (Branch_taken) begin
            unique case (state_q)
                WAIT_S:  state_d = imem.rvalid ? FETCH_S : DRAIN_S;
                FETCH_S: state_d = imem.gnt ? DRAIN_S : FETCH_S;
                // A response is still owed in DRAIN; keep discarding so only one request is ever in flight.
                DRAIN_S: state_d = imem.rvalid ? FETCH_S : DRAIN_S;
                default: state_d = FETCH_S;
            endcase
        end else begin
            unique case (state_q)
                FETCH_S: if (imem.gnt)    state_d = WAIT_S;
                WAIT_S:  if (imem.rvalid) state_d = Freeze ? HOLD_S : FETCH_S;
                DRAIN_S: if (imem.rvalid) state_d = FETCH_S;
                HOLD_S:  if (!Freeze)     state_d = FETCH_S;
                default: state_d = FETCH_S;
            endcase
        end
    end

    always_comb begin
        imem.req   = rst && (state_q == FETCH_S);
        imem.addr  = pc_q;
        load_rsp   = 1'b0;
        load_skid  = 1'b0;
        drain_skid = 1'b0;
        if (!Branch_taken) begin
            load_rsp   = (state_q == WAIT_S) && imem.rvalid && !Freeze;
            load_skid  = (state_q == WAIT_S) && imem.rvalid && Freeze;
            drain_skid = (state_q == HOLD_S) && skid_valid && !Freeze;
        end
        advance = load_rsp || drain_skid;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            skid_valid <= 1'b0;
            skid_pc    <= '0;
            skid_instr <= '0;
        end else if (Branch_taken || drain_skid) begin
            skid_valid <= 1'b0;
        end else if (load_skid) begin
            skid_valid <= 1'b1;
            skid_pc    <= pc_inc;
            skid_instr <= imem.rdata;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            PC_out          <= '0;
            instruction_out <= '0;
            valid_out       <= 1'b0;
        end else if (Branch_taken) begin
            PC_out          <= '0;
            instruction_out <= '0;
            valid_out       <= 1'b0;
        end else if (load_rsp) begin
            PC_out          <= pc_inc;
            instruction_out <= imem.rdata;
            valid_out       <= 1'b1;
        end else if (drain_skid) begin
            PC_out          <= skid_pc;
            instruction_out <= skid_instr;
            valid_out       <= 1'b1;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_count <= '0;
            flush_count <= '0;
        end else begin
            if (advance && (fetch_count != '1)) fetch_count <= fetch_count + 32'd1;
            if (Branch_taken && (flush_count != '1)) flush_count <= flush_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: the bench itself plays instruction memory cycle by cycle.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        Freeze;
    logic        Branch_taken;
    logic [31:0] Branch_Address;
    logic [31:0] PC_out;
    logic [31:0] instruction_out;
    logic        valid_out;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_count;
    logic [15:0] flush_count;
`endif

    int n_checks = 0;
    int n_errors = 0;

    fetch_stage_if #(.W(32)) imem ();

    fetch_stage dut (
        .clk             (clk),
        .rst             (rst),
        .Freeze          (Freeze),
        .Branch_taken    (Branch_taken),
        .Branch_Address  (Branch_Address),
        .imem            (imem),
        .PC_out          (PC_out),
        .instruction_out (instruction_out),
        .valid_out       (valid_out)
`ifdef FETCH_PERF_CNT_EN
        ,
        .fetch_count     (fetch_count),
        .flush_count     (flush_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_ifid(input string tag, input logic v, input logic [31:0] ins, input logic [31:0] pc);
        chk({tag, "_valid"}, 32'(valid_out), 32'(v));
        chk({tag, "_instr"}, instruction_out, ins);
        chk({tag, "_pc"}, PC_out, pc);
    endtask

    initial begin
        rst = 1'b0; Freeze = 1'b0; Branch_taken = 1'b0; Branch_Address = '0;
        imem.gnt = 1'b0; imem.rvalid = 1'b0; imem.rdata = '0;
        #1;
        chk_ifid("rst", 1'b0, 32'h0, 32'h0);
        chk("rst_req", 32'(imem.req), 32'h0);
        step(); step();
        rst = 1'b1;
        #1;
        chk("t1_req", 32'(imem.req), 32'h1);
        chk("t1_addr", imem.addr, 32'h0);

        // 1: back-to-back fetch, rvalid one cycle after gnt
        imem.gnt = 1'b1; step();
        imem.gnt = 1'b0; chk("t1_wait_req", 32'(imem.req), 32'h0);
        imem.rvalid = 1'b1; imem.rdata = 32'hE3A01005; step();
        imem.rvalid = 1'b0;
        chk_ifid("t1", 1'b1, 32'hE3A01005, 32'h4);
        chk("t1_next_addr", imem.addr, 32'h4);

        // 2: response lands while frozen, held in skid for 3 cycles
        imem.gnt = 1'b1; step();
        imem.gnt = 1'b0; Freeze = 1'b1;
        imem.rvalid = 1'b1; imem.rdata = 32'h11; step();
        imem.rvalid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk_ifid("t2_frz", 1'b1, 32'hE3A01005, 32'h4);
            chk("t2_hold_req", 32'(imem.req), 32'h0);
            if (i < 2) step();
        end
        Freeze = 1'b0; step();
        chk_ifid("t2_rel", 1'b1, 32'h11, 32'h8);
        chk("t2_next_addr", imem.addr, 32'h8);

        // 3: branch in WAIT, stale response arrives two cycles later
        imem.gnt = 1'b1; step();
        imem.gnt = 1'b0; Branch_taken = 1'b1; Branch_Address = 32'h100; step();
        Branch_taken = 1'b0;
        chk_ifid("t3_flush", 1'b0, 32'h0, 32'h0);
        chk("t3_drain_req", 32'(imem.req), 32'h0);
        step();
        chk("t3_drain_req2", 32'(imem.req), 32'h0);
        imem.rvalid = 1'b1; imem.rdata = 32'hDEAD; step();
        imem.rvalid = 1'b0;
        chk_ifid("t3_stale", 1'b0, 32'h0, 32'h0);
        chk("t3_req", 32'(imem.req), 32'h1);
        chk("t3_addr", imem.addr, 32'h100);

        // 4: branch and rvalid together under Freeze
        imem.gnt = 1'b1; step();
        imem.gnt = 1'b0; imem.rvalid = 1'b1; imem.rdata = 32'h55; step();
        imem.rvalid = 1'b0;
        chk_ifid("t4_pre", 1'b1, 32'h55, 32'h104);
        imem.gnt = 1'b1; step();
        imem.gnt = 1'b0; Freeze = 1'b1; Branch_taken = 1'b1; Branch_Address = 32'h200;
        imem.rvalid = 1'b1; imem.rdata = 32'hBAD; step();
        Branch_taken = 1'b0; imem.rvalid = 1'b0;
        chk_ifid("t4_flush", 1'b0, 32'h0, 32'h0);
        chk("t4_req", 32'(imem.req), 32'h1);
        chk("t4_addr", imem.addr, 32'h200);
        step();
        chk_ifid("t4_frz", 1'b0, 32'h0, 32'h0);
        Freeze = 1'b0; imem.gnt = 1'b1; step();
        imem.gnt = 1'b0; imem.rvalid = 1'b1; imem.rdata = 32'h77; step();
        imem.rvalid = 1'b0;
        chk_ifid("t4_post", 1'b1, 32'h77, 32'h204);

        // 5: PC wrap at the top of the address space
        Branch_taken = 1'b1; Branch_Address = 32'hFFFF_FFFC; step();
        Branch_taken = 1'b0;
        chk("t5_addr", imem.addr, 32'hFFFF_FFFC);
        imem.gnt = 1'b1; step();
        imem.gnt = 1'b0; imem.rvalid = 1'b1; imem.rdata = 32'h99; step();
        imem.rvalid = 1'b0;
        chk_ifid("t5_wrap", 1'b1, 32'h99, 32'h0);
        chk("t5_next_addr", imem.addr, 32'h0);

`ifdef FETCH_PERF_CNT_EN
        chk("perf_fetch", fetch_count, 32'd5);
        chk("perf_flush", 32'(flush_count), 32'd3);
`endif

        // 6: asynchronous reset in the middle of WAIT
        imem.gnt = 1'b1; step();
        imem.gnt = 1'b0;
        #2 rst = 1'b0;
        #1;
        chk_ifid("t6_async", 1'b0, 32'h0, 32'h0);
        chk("t6_req", 32'(imem.req), 32'h0);
        step(); step();
        chk("t6_req_held", 32'(imem.req), 32'h0);
`ifdef FETCH_PERF_CNT_EN
        chk("perf_fetch_rst", fetch_count, 32'd0);
`endif
        rst = 1'b1;
        #1;
        chk("t6_req_rel", 32'(imem.req), 32'h1);
        chk("t6_addr", imem.addr, 32'h0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
